cpld_rommap_ctrl: RTL and testbench
===================================

Name: cpld_rommap_ctrl

Overview:
Programmable upper/lower ROM slot-mapping controller for the six-socket (three dual-16K device) ROM board. It tracks the CPC upper-ROM select register (I/O &DFxx) and owns a 6-entry bank-to-ROM-number map table plus a lower-ROM enable. At reset the table is loaded from DIP switches; software may rewrite it through a key-protected configuration port. It drives the per-16K-bank chip-select vector and ROMDIS, from which board-level socket selects and A14 are derived.

Parameters:
CFG_PORT, 8'hFE, A15..A8 value decoding the configuration port
KEY0, 8'hA5, first unlock byte
KEY1, 8'h5A, second unlock byte
LOCK_CODE, 8'hFF, byte written in UNLOCKED state that relocks

Ports:
clk  input  1  CPC 4 MHz clock; all registers rising-edge
reset_b  input  1  asynchronous active-low reset
adr_hi  input  8  Z80 A15..A8
ioreq_b  input  1  Z80 IORQ, active low
wr_b  input  1  Z80 WR, active low
data  input  8  Z80 data bus
dip  input  8  board DIP switches, static
adr14_mem  input  1  Z80 A14 for the current memory cycle
rom16k_cs  output  6  per-bank select, bit i = bank i
romdis  output  1  OR of rom16k_cs
romsel_q  output  8  current upper-ROM number
cfg_unlocked  output  1  high in states UNLOCKED and GOT_IDX

Behaviour:
- iowr = !ioreq_b & !wr_b, registered each clk; write event = iowr & !iowr_d (single one-cycle pulse per I/O cycle, data sampled in that same cycle).
- romsel event: write event & adr_hi[7]&adr_hi[6]&!adr_hi[5]; romsel_q <= data next edge.
- cfg event: write event & adr_hi==CFG_PORT. Port sets are disjoint (CFG_PORT has A13=1).
- Reset (async): romsel_q=0, all map entries=8'hFF, low_en=0, state=INIT, iowr_d=0; hence rom16k_cs=0, romdis=0, cfg_unlocked=0.
- INIT (one clk after reset release): map[i] <= dip[i] ? base+i : 8'hFF for i=0..5; base per dip[7:6]: 00->1, 01->8, 10->10, 11->0; low_en <= dip[0] & !dip[7]; -> LOCKED. Later DIP changes ignored until next reset.
- FSM (advances only on cfg event; otherwise holds):
  LOCKED: data==KEY0 -> KEY1ST, else LOCKED.
  KEY1ST: data==KEY1 -> UNLOCKED, else LOCKED.
  UNLOCKED: data==LOCK_CODE -> LOCKED; data<=6 -> GOT_IDX, idx<=data[2:0]; other values ignored, stay.
  GOT_IDX: idx<=5: map[idx]<=data; idx==6: low_en<=data[0]; -> UNLOCKED.
- A cfg event during INIT is ignored.
- Map write takes effect on the rom16k_cs output the clock after the GOT_IDX data write; romsel write likewise one clock after the event.
- Decode (combinational from registers and adr14_mem):
  adr14_mem=0: rom16k_cs = {5'b0, low_en}.
  adr14_mem=1: bit i = (map[i]!=8'hFF) & (map[i]==romsel_q); multiple equal entries may assert multiple bits (software error, no priority applied).
- romdis = |rom16k_cs.
- Reset mid-sequence (any state) returns to INIT then LOCKED; map reloads from DIP.

Test Plan:
- dip=8'b00_111110, reset release -> after 2 clk map={6,5,4,3,2,FF}(bank5..0), low_en=0; OUT &DF00,3 then adr14_mem=1 -> rom16k_cs=6'b000100, romdis=1.
- dip=8'b01_000001, adr14_mem=0 -> rom16k_cs=6'b000001; dip=8'b10_000001 -> low_en=0, rom16k_cs=0.
- Unlock: OUT &FE00 A5,5A,02,07 then OUT &DF00,7, adr14_mem=1 -> rom16k_cs=6'b000100, cfg_unlocked=1; OUT &FE00,FF -> cfg_unlocked=0.
- Bad key: OUT &FE00 A5,00,02,07 -> state LOCKED, map[2] unchanged, cfg_unlocked never 1.
- IORQ/WR held low 3 clk on &DF00 with data changing -> exactly one romsel_q update with first-cycle data.
- Assert reset_b low while in GOT_IDX -> outputs 0 immediately; after release map equals DIP defaults, software edits lost.

Source files
------------

// File: rtl/cpld_rommap_ctrl.sv
// ROM slot-mapping controller: tracks the upper-ROM select register, holds a
// DIP-loaded, key-protected 6-entry bank map and decodes per-16K-bank selects.
module cpld_rommap_ctrl #(
  parameter logic [7:0] CFG_PORT  = 8'hFE,
  parameter logic [7:0] KEY0      = 8'hA5,
  parameter logic [7:0] KEY1      = 8'h5A,
  parameter logic [7:0] LOCK_CODE = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic [7:0] adr_hi,
  input  logic       ioreq_b,
  input  logic       wr_b,
  input  logic [7:0] data,
  input  logic [7:0] dip,
  input  logic       adr14_mem,
  output logic [5:0] rom16k_cs,
  output logic       romdis,
  output logic [7:0] romsel_q,
  output logic       cfg_unlocked
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_LOCKED   = 3'd1,
    ST_KEY1ST   = 3'd2,
    ST_UNLOCKED = 3'd3,
    ST_GOT_IDX  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        iowr_q;
  logic [7:0]  romsel_d;
  logic [2:0]  idx_q, idx_d;
  logic        low_en_q, low_en_d;
  logic [7:0]  map_q [6];
  logic [7:0]  map_d [6];

  logic        iowr_s;
  logic        wr_evt_s;
  logic        romsel_evt_s;
  logic        cfg_evt_s;
  logic [5:0]  cs_s;

  // First ROM number of the DIP-enabled bank run, chosen by dip[7:6]
  function automatic logic [7:0] dip_base(input logic [1:0] sel);
    logic [7:0] base;
    case (sel)
      2'b00:   base = 8'd1;
      2'b01:   base = 8'd8;
      2'b10:   base = 8'd10;
      2'b11:   base = 8'd0;
      default: base = 8'd0;
    endcase
    return base;
  endfunction

  // A held I/O write produces a single event on its first cycle
  assign iowr_s       = ~ioreq_b & ~wr_b;
  assign wr_evt_s     = iowr_s & ~iowr_q;
  assign romsel_evt_s = wr_evt_s & adr_hi[7] & adr_hi[6] & ~adr_hi[5];
  assign cfg_evt_s    = wr_evt_s & (adr_hi == CFG_PORT);

  // Upper-ROM select register next value
  always_comb begin
    romsel_d = romsel_q;
    if (romsel_evt_s) begin
      romsel_d = data;
    end else begin
      romsel_d = romsel_q;
    end
  end

  // Configuration FSM: DIP load in INIT, then key-protected map editing
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    low_en_d = low_en_q;
    for (int i = 0; i < 6; i++) begin
      map_d[i] = map_q[i];
    end
    case (state_q)
      ST_INIT: begin
        for (int i = 0; i < 6; i++) begin
          if (dip[i]) begin
            map_d[i] = dip_base(dip[7:6]) + 8'(i);
          end else begin
            map_d[i] = 8'hFF;
          end
        end
        low_en_d = dip[0] & ~dip[7];
        state_d  = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (cfg_evt_s && (data == KEY0)) begin
          state_d = ST_KEY1ST;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_KEY1ST: begin
        if (!cfg_evt_s) begin
          state_d = ST_KEY1ST;
        end else if (data == KEY1) begin
          state_d = ST_UNLOCKED;
        end else begin
          state_d = ST_LOCKED;
        end
      end
      ST_UNLOCKED: begin
        if (!cfg_evt_s) begin
          state_d = ST_UNLOCKED;
        end else if (data == LOCK_CODE) begin
          state_d = ST_LOCKED;
        end else if (data <= 8'd6) begin
          idx_d   = data[2:0];
          state_d = ST_GOT_IDX;
        end else begin
          state_d = ST_UNLOCKED;
        end
      end
      ST_GOT_IDX: begin
        if (cfg_evt_s) begin
          for (int i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) begin
              map_d[i] = data;
            end else begin
              map_d[i] = map_q[i];
            end
          end
          if (idx_q == 3'd6) begin
            low_en_d = data[0];
          end else begin
            low_en_d = low_en_q;
          end
          state_d = ST_UNLOCKED;
        end else begin
          state_d = ST_GOT_IDX;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State, map and select registers
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= ST_INIT;
      iowr_q   <= 1'b0;
      romsel_q <= 8'h00;
      idx_q    <= 3'd0;
      low_en_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        map_q[i] <= 8'hFF;
      end
    end else begin
      state_q  <= state_d;
      iowr_q   <= iowr_s;
      romsel_q <= romsel_d;
      idx_q    <= idx_d;
      low_en_q <= low_en_d;
      for (int i = 0; i < 6; i++) begin
        map_q[i] <= map_d[i];
      end
    end
  end

  // Bank decode; 8'hFF marks an unused bank and never matches
  always_comb begin
    cs_s = 6'b000000;
    if (!adr14_mem) begin
      cs_s = {5'b00000, low_en_q};
    end else begin
      for (int i = 0; i < 6; i++) begin
        cs_s[i] = (map_q[i] != 8'hFF) && (map_q[i] == romsel_q);
      end
    end
  end

  assign rom16k_cs    = cs_s;
  assign romdis       = |cs_s;
  assign cfg_unlocked = (state_q == ST_UNLOCKED) || (state_q == ST_GOT_IDX);

endmodule

// File: tb/tb_cpld_rommap_ctrl.sv
// Directed self-checking bench for cpld_rommap_ctrl.
module tb_cpld_rommap_ctrl;

  logic       clk;
  logic       reset_b;
  logic [7:0] adr_hi;
  logic       ioreq_b;
  logic       wr_b;
  logic [7:0] data;
  logic [7:0] dip;
  logic       adr14_mem;
  logic [5:0] rom16k_cs;
  logic       romdis;
  logic [7:0] romsel_q;
  logic       cfg_unlocked;

  int n_vec;
  int n_err;

  cpld_rommap_ctrl dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .adr_hi       (adr_hi),
    .ioreq_b      (ioreq_b),
    .wr_b         (wr_b),
    .data         (data),
    .dip          (dip),
    .adr14_mem    (adr14_mem),
    .rom16k_cs    (rom16k_cs),
    .romdis       (romdis),
    .romsel_q     (romsel_q),
    .cfg_unlocked (cfg_unlocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle OUT (A15..A8 = a), returns on the negedge after the event edge
  task automatic io_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    adr_hi  = a;
    data    = d;
    ioreq_b = 1'b0;
    wr_b    = 1'b0;
    @(negedge clk);
    ioreq_b = 1'b1;
    wr_b    = 1'b1;
  endtask

  // Reset with the given DIP setting; checks the asynchronous clear
  task automatic do_reset(input logic [7:0] dip_v);
    @(negedge clk);
    #2;
    reset_b = 1'b0;
    dip     = dip_v;
    #1;
    n_vec++;
    if ({rom16k_cs, romdis, romsel_q, cfg_unlocked} !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_clear: cs=%b romdis=%b romsel=%h unl=%b, want all 0",
               rom16k_cs, romdis, romsel_q, cfg_unlocked);
    end
    @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic unlock();
    io_write(8'hFE, 8'hA5);
    io_write(8'hFE, 8'h5A);
  endtask

  task automatic test_reset();
    adr14_mem = 1'b0;
    do_reset(8'b00_111110);
    n_vec++;
    if (rom16k_cs !== 6'b000000 || romdis !== 1'b0) begin
      n_err++;
      $display("FAIL reset_low_en: cs=%b romdis=%b, want 000000 0", rom16k_cs, romdis);
    end
    n_vec++;
    if (romsel_q !== 8'h00 || cfg_unlocked !== 1'b0) begin
      n_err++;
      $display("FAIL reset_regs: romsel=%h unl=%b, want 00 0", romsel_q, cfg_unlocked);
    end
  endtask

  // dip 00_111110: map = {6,5,4,3,2,FF} for banks 5..0
  task automatic test_dip_map();
    logic [5:0] exp_cs;
    adr14_mem = 1'b1;
    for (int v = 2; v <= 6; v++) begin
      io_write(8'hDF, 8'(v));
      exp_cs = 6'b000001 << (v - 1);
      n_vec++;
      if (rom16k_cs !== exp_cs || romdis !== 1'b1 || romsel_q !== 8'(v)) begin
        n_err++;
        $display("FAIL dip_map_%0d: cs=%b romdis=%b romsel=%h, want %b 1 %h",
                 v, rom16k_cs, romdis, romsel_q, exp_cs, 8'(v));
      end
    end
    io_write(8'hDF, 8'hFF);
    n_vec++;
    if (rom16k_cs !== 6'b000000 || romdis !== 1'b0) begin
      n_err++;
      $display("FAIL unused_ff: cs=%b romdis=%b, want 000000 0", rom16k_cs, romdis);
    end
    io_write(8'hDF, 8'h01);
    n_vec++;
    if (rom16k_cs !== 6'b000000) begin
      n_err++;
      $display("FAIL disabled_bank0: cs=%b, want 000000", rom16k_cs);
    end
  endtask

  task automatic test_low_en();
    adr14_mem = 1'b0;
    do_reset(8'b01_000001);
    n_vec++;
    if (rom16k_cs !== 6'b000001 || romdis !== 1'b1) begin
      n_err++;
      $display("FAIL low_en_on: cs=%b romdis=%b, want 000001 1", rom16k_cs, romdis);
    end
    adr14_mem = 1'b1;
    io_write(8'hDF, 8'h08);
    n_vec++;
    if (rom16k_cs !== 6'b000001) begin
      n_err++;
      $display("FAIL base8: cs=%b, want 000001", rom16k_cs);
    end
    adr14_mem = 1'b0;
    do_reset(8'b10_000001);
    n_vec++;
    if (rom16k_cs !== 6'b000000 || romdis !== 1'b0) begin
      n_err++;
      $display("FAIL low_en_off: cs=%b romdis=%b, want 000000 0", rom16k_cs, romdis);
    end
    do_reset(8'b11_000001);
    adr14_mem = 1'b1;
    #1;
    n_vec++;
    if (rom16k_cs !== 6'b000001) begin
      n_err++;
      $display("FAIL base0: cs=%b, want 000001", rom16k_cs);
    end
  endtask

  task automatic test_unlock();
    adr14_mem = 1'b1;
    do_reset(8'b00_111110);
    io_write(8'hFE, 8'hA5);
    n_vec++;
    if (cfg_unlocked !== 1'b0) begin
      n_err++;
      $display("FAIL key1st_unl: got %b, want 0", cfg_unlocked);
    end
    io_write(8'hFE, 8'h5A);
    n_vec++;
    if (cfg_unlocked !== 1'b1) begin
      n_err++;
      $display("FAIL unlocked: got %b, want 1", cfg_unlocked);
    end
    io_write(8'hFE, 8'h02);
    io_write(8'hFE, 8'h07);
    io_write(8'hDF, 8'h07);
    n_vec++;
    if (rom16k_cs !== 6'b000100 || romdis !== 1'b1 || cfg_unlocked !== 1'b1) begin
      n_err++;
      $display("FAIL map2_edit: cs=%b romdis=%b unl=%b, want 000100 1 1",
               rom16k_cs, romdis, cfg_unlocked);
    end
    io_write(8'hFE, 8'hFF);
    n_vec++;
    if (cfg_unlocked !== 1'b0) begin
      n_err++;
      $display("FAIL relock: got %b, want 0", cfg_unlocked);
    end
  endtask

  task automatic test_idx_edges();
    do_reset(8'b00_111110);
    unlock();
    io_write(8'hFE, 8'h06);
    io_write(8'hFE, 8'h01);
    adr14_mem = 1'b0;
    #1;
    n_vec++;
    if (rom16k_cs !== 6'b000001) begin
      n_err++;
      $display("FAIL idx6_low_en: cs=%b, want 000001", rom16k_cs);
    end
    io_write(8'hFE, 8'h07);
    n_vec++;
    if (cfg_unlocked !== 1'b1) begin
      n_err++;
      $display("FAIL idx7_ignored: unl=%b, want 1", cfg_unlocked);
    end
    io_write(8'hFE, 8'h04);
    io_write(8'hFE, 8'h03);
    io_write(8'hDF, 8'h03);
    adr14_mem = 1'b1;
    #1;
    n_vec++;
    if (rom16k_cs !== 6'b010100) begin
      n_err++;
      $display("FAIL dup_entries: cs=%b, want 010100", rom16k_cs);
    end
    io_write(8'hFE, 8'hFF);
  endtask

  task automatic test_bad_key();
    logic seen_unl;
    logic [7:0] seq [4];
    seq[0] = 8'hA5; seq[1] = 8'h00; seq[2] = 8'h02; seq[3] = 8'h07;
    seen_unl = 1'b0;
    do_reset(8'b00_111110);
    for (int k = 0; k < 4; k++) begin
      io_write(8'hFE, seq[k]);
      seen_unl = seen_unl | cfg_unlocked;
    end
    n_vec++;
    if (seen_unl !== 1'b0) begin
      n_err++;
      $display("FAIL bad_key_unl: got %b, want 0", seen_unl);
    end
    adr14_mem = 1'b1;
    io_write(8'hDF, 8'h03);
    n_vec++;
    if (rom16k_cs !== 6'b000100) begin
      n_err++;
      $display("FAIL bad_key_map: cs=%b, want 000100", rom16k_cs);
    end
    io_write(8'hDF, 8'h07);
    n_vec++;
    if (rom16k_cs !== 6'b000000) begin
      n_err++;
      $display("FAIL bad_key_no7: cs=%b, want 000000", rom16k_cs);
    end
  endtask

  task automatic test_held_write();
    logic [7:0] later [3];
    later[0] = 8'h0A; later[1] = 8'h0B; later[2] = 8'h0C;
    @(negedge clk);
    adr_hi  = 8'hDF;
    data    = 8'h05;
    ioreq_b = 1'b0;
    wr_b    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_vec++;
      if (romsel_q !== 8'h05) begin
        n_err++;
        $display("FAIL held_write_%0d: romsel=%h, want 05", k, romsel_q);
      end
      data = later[k];
    end
    ioreq_b = 1'b1;
    wr_b    = 1'b1;
    @(negedge clk);
    n_vec++;
    if (romsel_q !== 8'h05) begin
      n_err++;
      $display("FAIL held_release: romsel=%h, want 05", romsel_q);
    end
  endtask

  task automatic test_reset_mid();
    adr14_mem = 1'b1;
    do_reset(8'b00_111110);
    unlock();
    io_write(8'hFE, 8'h03);
    io_write(8'hFE, 8'h09);
    io_write(8'hDF, 8'h09);
    n_vec++;
    if (rom16k_cs !== 6'b001000) begin
      n_err++;
      $display("FAIL map3_edit: cs=%b, want 001000", rom16k_cs);
    end
    io_write(8'hFE, 8'h02);
    n_vec++;
    if (cfg_unlocked !== 1'b1) begin
      n_err++;
      $display("FAIL got_idx_unl: got %b, want 1", cfg_unlocked);
    end
    do_reset(8'b00_111110);
    io_write(8'hDF, 8'h09);
    n_vec++;
    if (rom16k_cs !== 6'b000000 || cfg_unlocked !== 1'b0) begin
      n_err++;
      $display("FAIL edit_lost: cs=%b unl=%b, want 000000 0", rom16k_cs, cfg_unlocked);
    end
    io_write(8'hDF, 8'h04);
    n_vec++;
    if (rom16k_cs !== 6'b001000) begin
      n_err++;
      $display("FAIL dip_restored: cs=%b, want 001000", rom16k_cs);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset_b   = 1'b0;
    adr_hi    = 8'h00;
    data      = 8'h00;
    ioreq_b   = 1'b1;
    wr_b      = 1'b1;
    dip       = 8'h00;
    adr14_mem = 1'b0;
    test_reset();
    test_dip_map();
    test_held_write();
    test_low_en();
    test_unlock();
    test_idx_edges();
    test_bad_key();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
